// File: rtl/cache_arb_pkg.sv
// Shared types and default widths for the cache/main-memory arbiter.
package cache_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 28;
  localparam int unsigned LINE_W_DEF = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Cache-side and memory-side bus of the arbiter.
// The slave view is the arbiter; the master view is the caches plus main memory.
interface cache_mem_arbiter_if
  import cache_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned LINE_W = LINE_W_DEF
);

  logic              I_READ;
  logic [ADDR_W-1:0] I_ADDR;
  logic [LINE_W-1:0] I_READDATA;
  logic              I_BUSYWAIT;

  logic              D_READ;
  logic              D_WRITE;
  logic [ADDR_W-1:0] D_ADDR;
  logic [LINE_W-1:0] D_WRITEDATA;
  logic [LINE_W-1:0] D_READDATA;
  logic              D_BUSYWAIT;

  logic              MEM_READ;
  logic              MEM_WRITE;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [LINE_W-1:0] MEM_WRITEDATA;
  logic [LINE_W-1:0] MEM_READDATA;
  logic              MEM_BUSYWAIT;

  modport slave (
    input  I_READ, I_ADDR, D_READ, D_WRITE, D_ADDR, D_WRITEDATA,
    input  MEM_READDATA, MEM_BUSYWAIT,
    output I_READDATA, I_BUSYWAIT, D_READDATA, D_BUSYWAIT,
    output MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WRITEDATA
  );

  modport master (
    output I_READ, I_ADDR, D_READ, D_WRITE, D_ADDR, D_WRITEDATA,
    output MEM_READDATA, MEM_BUSYWAIT,
    input  I_READDATA, I_BUSYWAIT, D_READDATA, D_BUSYWAIT,
    input  MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WRITEDATA
  );

endinterface

// File: rtl/cache_mem_arbiter_rr.sv
// Combinational 2-way round-robin picker; bit 0 is icache, bit 1 is dcache.
module rr_arbiter_2
  import cache_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  owner_t     i_last_owner,
  output logic       o_grant_valid,
  output owner_t     o_grant_id
);

  // A lone requester wins; on a tie the one that did not win last time wins.
  always_comb begin
    o_grant_valid = |i_req;
    o_grant_id    = OWN_I;
    if (i_req == 2'b11) begin
      o_grant_id = (i_last_owner == OWN_I) ? OWN_D : OWN_I;
    end else if (i_req[1]) begin
      o_grant_id = OWN_D;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares the main-memory line port between icache and dcache, one transaction at a time.
module cache_mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned LINE_W = LINE_W_DEF
) (
  input logic                CLK,
  input logic                RESET,
  cache_mem_arbiter_if.slave bus
);

  state_t            r_state;
  state_t            w_state_nxt;
  owner_t            r_owner;
  owner_t            r_last_owner;
  owner_t            w_grant_id;
  logic              w_grant_valid;
  logic              w_grant;
  logic              w_done;
  logic              w_grant_wr;
  logic [ADDR_W-1:0] w_grant_addr;
  logic              w_i_req;
  logic              w_d_req;

  logic              r_mem_read;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [LINE_W-1:0] r_mem_wdata;
  logic [LINE_W-1:0] r_i_rdata;
  logic [LINE_W-1:0] r_d_rdata;

  assign w_i_req = bus.I_READ;
  assign w_d_req = bus.D_READ | bus.D_WRITE;

  rr_arbiter_2 u_rr (
    .i_req         ({w_d_req, w_i_req}),
    .i_last_owner  (r_last_owner),
    .o_grant_valid (w_grant_valid),
    .o_grant_id    (w_grant_id)
  );

  // A simultaneous dcache read+write performs the write.
  assign w_grant_wr   = (w_grant_id == OWN_D) && bus.D_WRITE;
  assign w_grant_addr = (w_grant_id == OWN_D) ? bus.D_ADDR : bus.I_ADDR;

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic with grant and completion strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant_valid) begin
          w_state_nxt = ISSUE;
          w_grant     = 1'b1;
        end
      end
      ISSUE: w_state_nxt = WAIT;
      WAIT: begin
        if (!bus.MEM_BUSYWAIT) begin
          w_state_nxt = RESP;
          w_done      = 1'b1;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Latch the granted request, drive memory, capture the response for a still-waiting owner.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_owner      <= OWN_I;
      r_last_owner <= OWN_I;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_i_rdata    <= '0;
      r_d_rdata    <= '0;
    end else begin
      if (w_grant) begin
        r_owner      <= w_grant_id;
        r_last_owner <= w_grant_id;
        r_mem_read   <= !w_grant_wr;
        r_mem_write  <= w_grant_wr;
        r_mem_addr   <= w_grant_addr;
        if (w_grant_wr) r_mem_wdata <= bus.D_WRITEDATA;
      end
      if (w_done) begin
        r_mem_read  <= 1'b0;
        r_mem_write <= 1'b0;
        if (r_owner == OWN_I && w_i_req) r_i_rdata <= bus.MEM_READDATA;
        if (r_owner == OWN_D && w_d_req) r_d_rdata <= bus.MEM_READDATA;
      end
    end
  end

  assign bus.MEM_READ      = r_mem_read;
  assign bus.MEM_WRITE     = r_mem_write;
  assign bus.MEM_ADDR      = r_mem_addr;
  assign bus.MEM_WRITEDATA = r_mem_wdata;
  assign bus.I_READDATA    = r_i_rdata;
  assign bus.D_READDATA    = r_d_rdata;

  // Busy-wait drops only in the owner's RESP cycle.
  assign bus.I_BUSYWAIT = w_i_req && !(r_state == RESP && r_owner == OWN_I);
  assign bus.D_BUSYWAIT = w_d_req && !(r_state == RESP && r_owner == OWN_D);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed self-checking bench for cache_mem_arbiter.
module tb_cache_mem_arbiter;

  localparam logic [127:0] LINE_A = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
  localparam logic [127:0] LINE_B = 128'h0F0F0F0F_12345678_9ABCDEF0_A5A5A5A5;
  localparam logic [127:0] LINE_C = 128'hCAFEBABE_00000001_00000002_00000003;
  localparam logic [127:0] ONES   = 128'h11111111_11111111_11111111_11111111;

  logic CLK = 1'b0;
  logic RESET;

  cache_mem_arbiter_if bus_if ();

  cache_mem_arbiter dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus_if)
  );

  always #5 CLK = ~CLK;

  // Main-memory model: busy for mem_wait_n cycles after the cycle the strobe first appears.
  int           mem_wait_n;
  int           mem_cnt;
  logic         mem_seen;
  logic [127:0] mem_rdata;

  assign bus_if.MEM_BUSYWAIT = mem_seen && (mem_cnt != 0);
  assign bus_if.MEM_READDATA = mem_rdata;

  always @(posedge CLK) begin
    if (RESET) begin
      mem_seen <= 1'b0;
      mem_cnt  <= 0;
    end else if (bus_if.MEM_READ || bus_if.MEM_WRITE) begin
      if (!mem_seen) begin
        mem_seen <= 1'b1;
        mem_cnt  <= mem_wait_n;
      end else if (mem_cnt != 0) begin
        mem_cnt <= mem_cnt - 1;
      end
    end else begin
      mem_seen <= 1'b0;
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0;
  int i_rereq, d_rereq;
  int i_busy_idle, d_busy_idle;
  logic prev_strobe = 1'b0;

  logic [27:0]  g_addr[$];
  logic         g_rd[$];
  logic         g_wr[$];
  logic [127:0] g_wdata[$];
  int           g_cyc[$];
  int           ir_cyc[$];
  int           dr_cyc[$];
  logic [127:0] ir_data[$];
  logic [127:0] dr_data[$];

  task automatic clear_log();
    g_addr.delete(); g_rd.delete(); g_wr.delete(); g_wdata.delete(); g_cyc.delete();
    ir_cyc.delete(); dr_cyc.delete(); ir_data.delete(); dr_data.delete();
    i_busy_idle = 0; d_busy_idle = 0; i_rereq = 0; d_rereq = 0;
  endtask

  // One cycle: observe at the falling edge, log grants/responses, cache models drop or hold requests.
  task automatic tick();
    logic strobe;
    @(negedge CLK);
    cyc++;
    strobe = bus_if.MEM_READ | bus_if.MEM_WRITE;
    if (strobe && !prev_strobe) begin
      g_addr.push_back(bus_if.MEM_ADDR);
      g_rd.push_back(bus_if.MEM_READ);
      g_wr.push_back(bus_if.MEM_WRITE);
      g_wdata.push_back(bus_if.MEM_WRITEDATA);
      g_cyc.push_back(cyc);
    end
    prev_strobe = strobe;
    if (!bus_if.I_READ && bus_if.I_BUSYWAIT) i_busy_idle++;
    if (!bus_if.D_READ && !bus_if.D_WRITE && bus_if.D_BUSYWAIT) d_busy_idle++;
    if (bus_if.I_READ && !bus_if.I_BUSYWAIT) begin
      ir_cyc.push_back(cyc);
      ir_data.push_back(bus_if.I_READDATA);
      if (i_rereq > 0) i_rereq--;
      else bus_if.I_READ = 1'b0;
    end
    if ((bus_if.D_READ || bus_if.D_WRITE) && !bus_if.D_BUSYWAIT) begin
      dr_cyc.push_back(cyc);
      dr_data.push_back(bus_if.D_READDATA);
      if (d_rereq > 0) d_rereq--;
      else begin
        bus_if.D_READ  = 1'b0;
        bus_if.D_WRITE = 1'b0;
      end
    end
  endtask

  task automatic run_until(input int i_n, input int d_n, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (ir_cyc.size() >= i_n && dr_cyc.size() >= d_n) break;
      tick();
    end
    tick();
    tick();
  endtask

  task automatic apply_reset();
    bus_if.I_READ = 1'b0; bus_if.D_READ = 1'b0; bus_if.D_WRITE = 1'b0;
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    bus_if.I_ADDR = '0; bus_if.D_ADDR = '0; bus_if.D_WRITEDATA = '0;
    mem_wait_n = 0; mem_rdata = '0;
    bus_if.I_READ = 1'b0; bus_if.D_READ = 1'b0; bus_if.D_WRITE = 1'b0;
    RESET = 1'b1;
    tick();
    tick();
    checks++; if (bus_if.MEM_READ !== 1'b0) begin errors++; $display("FAIL reset_mem_read: got %b want 0", bus_if.MEM_READ); end
    checks++; if (bus_if.MEM_WRITE !== 1'b0) begin errors++; $display("FAIL reset_mem_write: got %b want 0", bus_if.MEM_WRITE); end
    checks++; if (bus_if.MEM_ADDR !== 28'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", bus_if.MEM_ADDR); end
    checks++; if (bus_if.MEM_WRITEDATA !== 128'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h want 0", bus_if.MEM_WRITEDATA); end
    checks++; if (bus_if.I_READDATA !== 128'h0) begin errors++; $display("FAIL reset_i_readdata: got %h want 0", bus_if.I_READDATA); end
    checks++; if (bus_if.D_READDATA !== 128'h0) begin errors++; $display("FAIL reset_d_readdata: got %h want 0", bus_if.D_READDATA); end
    checks++; if (bus_if.I_BUSYWAIT !== 1'b0) begin errors++; $display("FAIL reset_i_busywait: got %b want 0", bus_if.I_BUSYWAIT); end
    checks++; if (bus_if.D_BUSYWAIT !== 1'b0) begin errors++; $display("FAIL reset_d_busywait: got %b want 0", bus_if.D_BUSYWAIT); end
    RESET = 1'b0;
    tick();
  endtask

  task automatic test_lone_icache();
    clear_log();
    mem_wait_n = 3; mem_rdata = LINE_A;
    bus_if.I_ADDR = 28'h0000010; bus_if.I_READ = 1'b1;
    t0 = cyc;
    run_until(1, 0, 30);
    checks++; if (g_addr.size() !== 1) begin errors++; $display("FAIL lone_grant_count: got %0d want 1", g_addr.size()); end
    else begin
      checks++; if (g_addr[0] !== 28'h0000010) begin errors++; $display("FAIL lone_mem_addr: got %h want 0000010", g_addr[0]); end
      checks++; if (g_rd[0] !== 1'b1 || g_wr[0] !== 1'b0) begin errors++; $display("FAIL lone_strobes: got rd=%b wr=%b want rd=1 wr=0", g_rd[0], g_wr[0]); end
      checks++; if (g_cyc[0] !== t0 + 1) begin errors++; $display("FAIL lone_issue_cycle: got %0d want %0d", g_cyc[0] - t0, 1); end
    end
    checks++; if (ir_cyc.size() !== 1) begin errors++; $display("FAIL lone_resp_count: got %0d want 1", ir_cyc.size()); end
    else begin
      checks++; if (ir_cyc[0] !== t0 + 6) begin errors++; $display("FAIL lone_resp_cycle: got %0d want 6", ir_cyc[0] - t0); end
      checks++; if (ir_data[0] !== LINE_A) begin errors++; $display("FAIL lone_resp_data: got %h want %h", ir_data[0], LINE_A); end
    end
    checks++; if (dr_cyc.size() !== 0 || d_busy_idle !== 0) begin errors++; $display("FAIL lone_d_busywait: got resp=%0d busy=%0d want 0 0", dr_cyc.size(), d_busy_idle); end
    checks++; if (bus_if.I_READDATA !== LINE_A) begin errors++; $display("FAIL lone_readdata_hold: got %h want %h", bus_if.I_READDATA, LINE_A); end
    checks++; if (bus_if.MEM_READ !== 1'b0) begin errors++; $display("FAIL lone_strobe_clear: got %b want 0", bus_if.MEM_READ); end
  endtask

  task automatic test_tie_after_reset();
    apply_reset();
    clear_log();
    mem_wait_n = 1; mem_rdata = LINE_B;
    bus_if.I_ADDR = 28'h0000100; bus_if.D_ADDR = 28'h0000200;
    bus_if.I_READ = 1'b1; bus_if.D_READ = 1'b1;
    t0 = cyc;
    run_until(1, 1, 40);
    checks++; if (g_addr.size() !== 2) begin errors++; $display("FAIL tie_grant_count: got %0d want 2", g_addr.size()); end
    else begin
      checks++; if (g_addr[0] !== 28'h0000200) begin errors++; $display("FAIL tie_first_owner: got %h want 0000200", g_addr[0]); end
      checks++; if (g_addr[1] !== 28'h0000100) begin errors++; $display("FAIL tie_second_owner: got %h want 0000100", g_addr[1]); end
      checks++; if (g_cyc[1] - g_cyc[0] !== 5) begin errors++; $display("FAIL tie_grant_gap: got %0d want 5", g_cyc[1] - g_cyc[0]); end
    end
    checks++; if (dr_cyc.size() !== 1 || ir_cyc.size() !== 1) begin errors++; $display("FAIL tie_resp_count: got d=%0d i=%0d want 1 1", dr_cyc.size(), ir_cyc.size()); end
    else begin
      checks++; if (dr_cyc[0] !== t0 + 4) begin errors++; $display("FAIL tie_d_resp_cycle: got %0d want 4", dr_cyc[0] - t0); end
      checks++; if (ir_cyc[0] !== t0 + 9) begin errors++; $display("FAIL tie_i_resp_cycle: got %0d want 9", ir_cyc[0] - t0); end
      checks++; if (dr_data[0] !== LINE_B) begin errors++; $display("FAIL tie_d_data: got %h want %h", dr_data[0], LINE_B); end
    end
  endtask

  task automatic test_fairness();
    logic [27:0] exp_addr[4];
    apply_reset();
    clear_log();
    exp_addr[0] = 28'h0000200; exp_addr[1] = 28'h0000100;
    exp_addr[2] = 28'h0000200; exp_addr[3] = 28'h0000100;
    mem_wait_n = 0; mem_rdata = LINE_C;
    bus_if.I_ADDR = 28'h0000100; bus_if.D_ADDR = 28'h0000200;
    i_rereq = 1; d_rereq = 1;
    bus_if.I_READ = 1'b1; bus_if.D_READ = 1'b1;
    t0 = cyc;
    run_until(2, 2, 60);
    checks++; if (g_addr.size() !== 4) begin errors++; $display("FAIL fair_grant_count: got %0d want 4", g_addr.size()); end
    else begin
      for (int k = 0; k < 4; k++) begin
        checks++; if (g_addr[k] !== exp_addr[k]) begin errors++; $display("FAIL fair_grant_%0d: got %h want %h", k, g_addr[k], exp_addr[k]); end
      end
      checks++; if (g_cyc[3] - g_cyc[0] !== 12) begin errors++; $display("FAIL fair_span: got %0d want 12", g_cyc[3] - g_cyc[0]); end
    end
    checks++; if (ir_cyc.size() !== 2) begin errors++; $display("FAIL fair_i_count: got %0d want 2", ir_cyc.size()); end
    else begin
      checks++; if (ir_cyc[0] !== t0 + 7) begin errors++; $display("FAIL fair_i_first: got %0d want 7", ir_cyc[0] - t0); end
    end
  endtask

  task automatic test_write_back();
    clear_log();
    mem_wait_n = 2; mem_rdata = LINE_A;
    bus_if.D_ADDR = 28'h0ABCDEF; bus_if.D_WRITEDATA = ONES; bus_if.D_WRITE = 1'b1;
    t0 = cyc;
    run_until(0, 1, 30);
    checks++; if (g_addr.size() !== 1) begin errors++; $display("FAIL wb_grant_count: got %0d want 1", g_addr.size()); end
    else begin
      checks++; if (g_addr[0] !== 28'h0ABCDEF) begin errors++; $display("FAIL wb_addr: got %h want 0abcdef", g_addr[0]); end
      checks++; if (g_wr[0] !== 1'b1 || g_rd[0] !== 1'b0) begin errors++; $display("FAIL wb_strobes: got wr=%b rd=%b want wr=1 rd=0", g_wr[0], g_rd[0]); end
      checks++; if (g_wdata[0] !== ONES) begin errors++; $display("FAIL wb_data: got %h want %h", g_wdata[0], ONES); end
    end
    checks++; if (dr_cyc.size() !== 1) begin errors++; $display("FAIL wb_resp_count: got %0d want 1", dr_cyc.size()); end
    else begin
      checks++; if (dr_cyc[0] !== t0 + 5) begin errors++; $display("FAIL wb_resp_cycle: got %0d want 5", dr_cyc[0] - t0); end
    end
    checks++; if (ir_cyc.size() !== 0 || i_busy_idle !== 0) begin errors++; $display("FAIL wb_i_busywait: got resp=%0d busy=%0d want 0 0", ir_cyc.size(), i_busy_idle); end
  endtask

  task automatic test_zero_wait_back_to_back();
    clear_log();
    mem_wait_n = 0; mem_rdata = LINE_B;
    bus_if.I_ADDR = 28'h0000555; i_rereq = 2; bus_if.I_READ = 1'b1;
    t0 = cyc;
    run_until(3, 0, 40);
    checks++; if (ir_cyc.size() !== 3) begin errors++; $display("FAIL zw_resp_count: got %0d want 3", ir_cyc.size()); end
    else begin
      for (int k = 0; k < 3; k++) begin
        checks++; if (ir_cyc[k] !== t0 + 3 + 4 * k) begin errors++; $display("FAIL zw_resp_%0d: got %0d want %0d", k, ir_cyc[k] - t0, 3 + 4 * k); end
      end
      checks++; if (ir_data[0] !== LINE_B) begin errors++; $display("FAIL zw_data: got %h want %h", ir_data[0], LINE_B); end
    end
  endtask

  task automatic test_reset_mid_txn();
    clear_log();
    mem_wait_n = 5; mem_rdata = LINE_C;
    bus_if.D_ADDR = 28'h0000333; bus_if.D_READ = 1'b1;
    t0 = cyc;
    tick(); tick(); tick();
    checks++; if (bus_if.MEM_READ !== 1'b1) begin errors++; $display("FAIL rst_pre_strobe: got %b want 1", bus_if.MEM_READ); end
    RESET = 1'b1;
    tick();
    checks++; if (bus_if.MEM_READ !== 1'b0 || bus_if.MEM_WRITE !== 1'b0) begin errors++; $display("FAIL rst_strobes: got rd=%b wr=%b want 0 0", bus_if.MEM_READ, bus_if.MEM_WRITE); end
    checks++; if (bus_if.MEM_ADDR !== 28'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", bus_if.MEM_ADDR); end
    checks++; if (bus_if.D_BUSYWAIT !== 1'b1) begin errors++; $display("FAIL rst_d_busywait: got %b want 1", bus_if.D_BUSYWAIT); end
    bus_if.D_READ = 1'b0;
    RESET = 1'b0;
    tick(); tick(); tick(); tick();
    checks++; if (dr_cyc.size() !== 0) begin errors++; $display("FAIL rst_no_release: got %0d want 0", dr_cyc.size()); end
    checks++; if (bus_if.D_READDATA !== 128'h0) begin errors++; $display("FAIL rst_d_readdata: got %h want 0", bus_if.D_READDATA); end
    clear_log();
    mem_wait_n = 0; mem_rdata = LINE_A;
    bus_if.I_ADDR = 28'h0000444; bus_if.I_READ = 1'b1;
    t0 = cyc;
    run_until(1, 0, 20);
    checks++; if (ir_cyc.size() !== 1) begin errors++; $display("FAIL rst_fresh_count: got %0d want 1", ir_cyc.size()); end
    else begin
      checks++; if (ir_cyc[0] !== t0 + 3) begin errors++; $display("FAIL rst_fresh_cycle: got %0d want 3", ir_cyc[0] - t0); end
      checks++; if (ir_data[0] !== LINE_A) begin errors++; $display("FAIL rst_fresh_data: got %h want %h", ir_data[0], LINE_A); end
    end
  endtask

  initial begin
    RESET = 1'b1;
    bus_if.I_READ = 1'b0; bus_if.D_READ = 1'b0; bus_if.D_WRITE = 1'b0;
    bus_if.I_ADDR = '0; bus_if.D_ADDR = '0; bus_if.D_WRITEDATA = '0;
    mem_wait_n = 0; mem_rdata = '0;
    clear_log();
    test_reset();
    test_lone_icache();
    test_tie_after_reset();
    test_fairness();
    test_write_back();
    test_zero_wait_back_to_back();
    test_reset_mid_txn();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Shares the single main-memory block port between the instruction cache and the data cache of the RV32IM pipeline. Each cache raises a line-sized miss request (refill read, or write-back for dcache) with the existing busy-wait handshake. The arbiter grants one requester at a time with 2-way round-robin priority and runs the main-memory transaction. It returns read data and releases the requester's busy-wait for exactly one cycle.

## Interface
- ADDR_W, 28: block address width; word address [31:4] for 16-byte lines.
- LINE_W, 128: cache line width in bits.
- CLK  in  1  clock.
- RESET  in  1  reset; synchronous, active-high.
- I_READ  in  1  icache refill request.
- I_ADDR  in  ADDR_W  icache block address.
- I_READDATA  out  LINE_W  refill line to icache.
- I_BUSYWAIT  out  1  icache stall.
- D_READ  in  1  dcache refill request.
- D_WRITE  in  1  dcache write-back request.
- D_ADDR  in  ADDR_W  dcache block address.
- D_WRITEDATA  in  LINE_W  write-back line.
- D_READDATA  out  LINE_W  refill line to dcache.
- D_BUSYWAIT  out  1  dcache stall.
- MEM_READ, MEM_WRITE  out  1 each  main-memory request strobes.
- MEM_ADDR  out  ADDR_W  main-memory address.
- MEM_WRITEDATA  out  LINE_W  main-memory write line.
- MEM_READDATA  in  LINE_W  main-memory read line.
- MEM_BUSYWAIT  in  1  main memory busy.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any request is pending, pick the owner, latch its address, write data and op, and go to ISSUE. Otherwise stay in IDLE.
- Owner selection: a single requester wins. On a tie, the requester that is not LAST_OWNER wins. LAST_OWNER updates on every grant.
- ISSUE: MEM_READ or MEM_WRITE is high with the latched address and data. The next state is always WAIT. Main memory must raise MEM_BUSYWAIT by the cycle after the strobe first appears.
- WAIT: hold the strobes. On the edge where MEM_BUSYWAIT is 0, latch MEM_READDATA into the owner's readdata register, clear the strobes, and go to RESP.
- RESP: the owner's busy-wait is 0 for this one cycle and its readdata is valid. The next state is always IDLE.
- Busy-wait rules:
  - I_BUSYWAIT = I_READ && !(state==RESP && owner==I).
  - D_BUSYWAIT = (D_READ||D_WRITE) && !(state==RESP && owner==D).
  - Both are combinational from registered state.
- D_READ and D_WRITE together is illegal. If it occurs, the write is performed.
- A write-back followed by a refill arrives as two separate dcache requests. A pending icache request may be served between them.
- A requester dropping its request mid-transaction is illegal. The arbiter completes the memory transaction anyway and discards the response; the next state is still RESP, then IDLE.
- I_READDATA and D_READDATA hold their last latched value until the next response to that requester.

## Timing
- Reset values: state=IDLE, LAST_OWNER=I (so the first tie goes to dcache), MEM_READ=MEM_WRITE=0, MEM_ADDR=0, MEM_WRITEDATA=0, I_READDATA=D_READDATA=0.
- Busy-wait outputs follow their requests combinationally, so they are 0 while their request is low.
- Minimum latency for a request raised in cycle 0 against zero-wait memory:
  - edge 1: enter ISSUE;
  - edge 2: enter WAIT;
  - edge 3: enter RESP (MEM_BUSYWAIT=0);
  - busy-wait is low in cycle 3;
  - edge 4: back to IDLE.
- An N-cycle memory adds N cycles in WAIT.
- Back-to-back grants: one IDLE cycle separates consecutive transactions, so the throughput is at most 1 transaction per 4 cycles.
- RESET mid-transaction: takes effect at the next edge regardless of state. Strobes are cleared, the transaction is abandoned, and no RESP is generated.
- Strobes and address change only on the edges entering ISSUE (set) and RESP (clear). They are stable throughout WAIT.

## Structure
- Shared package cache_arb_pkg:
  - state enum (IDLE, ISSUE, WAIT, RESP);
  - owner encoding (OWN_I=0, OWN_D=1);
  - default ADDR_W and LINE_W constants.
- Sub-module rr_arbiter_2: combinational 2-way round-robin picker. Inputs are req[1:0] and last_owner; outputs are grant_valid and grant_id. It is instantiated once; LAST_OWNER is stored in the parent.
- The parent holds the FSM, the latched request, and the readdata registers.

## Test plan
- Lone icache: I_READ=1, I_ADDR=0x0000010, memory returns 0xDEADBEEF_CAFEF00D_01234567_89ABCDEF after 3 wait cycles. Required: MEM_READ=1 with MEM_ADDR=0x0000010, I_BUSYWAIT low for exactly one cycle with I_READDATA equal to that line, D_BUSYWAIT=0 throughout.
- Tie after reset: I_READ and D_READ both raised in the same cycle. Required: dcache is served first, then icache, with one IDLE cycle between grants.
- Fairness: dcache re-requests immediately after each RESP while icache holds I_READ. Required: grants alternate D,I,D,I; icache waits no more than one dcache transaction.
- Write-back: D_WRITE=1, D_ADDR=0x0ABCDEF, D_WRITEDATA=0x11..11. Required: MEM_WRITE=1 with that address and data, MEM_READ=0, and D_BUSYWAIT low for one cycle on completion.
- Zero-wait memory (MEM_BUSYWAIT tied 0): required response in cycle 3 and a 4-cycle period for back-to-back requests.
- RESET asserted during WAIT. Required: state is IDLE and strobes are 0 after the next edge. No busy-wait release occurs for the abandoned request. A fresh request after reset completes normally.
